acq_search_ctrl: RTL and testbench
==================================

// Module: acq_search_ctrl
// PURPOSE
//  Sequences the shared acquisition correlator inside gnss_receiver_top: sweeps PRN x Doppler bin x code phase.
//  Issues one correlation request per cell and keeps the peak magnitude per PRN.
//  Emits one result record per PRN (found/not-found vs threshold) to the channel-assignment logic.
//  Sits between the control/config registers and the correlator engine.
// PARAMETERS
//  N_DOPPLER    21    Doppler bins per PRN; index 0..N_DOPPLER-1 (centre bin = N_DOPPLER/2)
//  CODE_PHASES  1023  code-phase cells per Doppler bin; index 0..CODE_PHASES-1
//  MAG_W        24    correlator magnitude width (unsigned)
//  TIMEOUT_CYC  4096  max cycles waiting for corr_done before error
// PORTS
//  sys_clk         in   1       system clock, all logic rising-edge
//  rst_n           in   1       asynchronous active-low reset
//  start           in   1       pulse: begin sweep (honoured only in IDLE)
//  abort           in   1       pulse: terminate sweep, return to IDLE
//  prn_first       in   6       first PRN to search (1..32)
//  prn_last        in   6       last PRN to search, inclusive
//  threshold       in   MAG_W   detection threshold, sampled at start
//  corr_start      out  1       one-cycle request to correlator
//  corr_prn        out  6       PRN for current cell
//  corr_dopp_idx   out  $clog2(N_DOPPLER)    Doppler bin for current cell
//  corr_code_phase out  $clog2(CODE_PHASES)  code phase for current cell
//  corr_done       in   1       one-cycle pulse: correlation complete
//  corr_mag        in   MAG_W   magnitude, valid with corr_done
//  res_valid       out  1       result record valid (held until accepted)
//  res_ready       in   1       consumer accepts record when res_valid & res_ready
//  res_prn/res_dopp_idx/res_code_phase/res_mag  out  (as corr_*, MAG_W)  peak cell of the PRN
//  res_found       out  1       res_mag > threshold (strict)
//  busy            out  1       high whenever state != IDLE
//  done            out  1       one-cycle pulse after the last PRN record is accepted
//  error           out  1       sticky: timeout or bad range; cleared by next accepted start
// BEHAVIOUR
//  Reset: state IDLE; every output 0; counters, best registers and the threshold latch cleared.
//  States: IDLE -> CONFIG -> WAIT -> EVAL -> (CONFIG | REPORT) ; REPORT -> (CONFIG | IDLE).
//  IDLE: on start with prn_first<=prn_last, latch range and threshold, clear error, PRN=prn_first, dopp=0, phase=0.
//   Next cycle -> CONFIG. On start with prn_first>prn_last, set error and stay in IDLE.
//  CONFIG: corr_start=1 for exactly this cycle; corr_* are stable from CONFIG until EVAL exit. -> WAIT.
//  WAIT: timeout counter runs. On corr_done, capture corr_mag -> EVAL.
//   At TIMEOUT_CYC cycles without corr_done: set error -> IDLE (no record, no done).
//  EVAL (1 cycle): if captured mag > best_mag (strict; ties keep the earlier cell), update best_* to the current cell.
//   Increment order: phase innermost, then Doppler; phase wraps CODE_PHASES-1 -> 0 with dopp++.
//   Last cell (dopp=N_DOPPLER-1, phase=CODE_PHASES-1) -> REPORT, else -> CONFIG.
//  REPORT: res_valid=1, res_* = best_*, res_found = best_mag > threshold_latched. Held stable until res_ready.
//   On accept: clear best_mag to 0 and best cell to 0.
//   If PRN == prn_last: done pulses in the accept cycle -> IDLE. Else PRN++, dopp=phase=0 -> CONFIG.
//  Per-cell cost: 1 (CONFIG) + correlator latency + 1 (EVAL) cycles.
//  All-zero magnitudes: the best cell stays (dopp 0, phase 0) with res_mag=0.
//  corr_done outside WAIT is ignored. start while busy is ignored. Range inputs are not re-read mid-sweep.
//  abort (any state, has priority over all transitions): next state IDLE.
//   corr_start and res_valid deassert the following cycle; no done pulse; error unchanged.
//  abort and start together in IDLE: abort wins; start is ignored.
//  rst_n assertion mid-sweep returns to reset state immediately (async); no record is emitted.
// TESTING (N_DOPPLER=3, CODE_PHASES=4, TIMEOUT_CYC=16 for speed)
//  1. start, prn 5..5, thr=100; model returns mag=200 only at dopp1/phase2, 10 elsewhere, latency 3
//     -> 12 corr_start pulses, one record {prn5, d1, p2, mag200, found=1}, then done pulse.
//  2. prn 1..3, thr=500, all mags 50 -> 3 records in PRN order 1,2,3, found=0, res_mag=50 at d0/p0 (ties keep first).
//  3. Hold res_ready low 10 cycles on the first record -> res_* stable and no corr_start while held.
//     Release -> next PRN sweep starts.
//  4. Correlator never returns corr_done -> error=1 after 16 WAIT cycles, busy=0, no done.
//     The next valid start clears error.
//  5. abort during WAIT of cell 7 -> busy=0 next cycle, no record.
//     A late corr_done is ignored; a fresh start sweeps from cell 0.
//  6. prn_first=9, prn_last=4 -> error=1, busy stays 0. Also: start during sweep is ignored.
//     Also: rst_n low mid-REPORT -> all outputs 0.

Source files
------------

// File: rtl/acq_search_ctrl_if.sv
// Correlator request/response and per-PRN result record signals of the acquisition search controller.
// The controller uses the master view; the correlator and channel-assignment logic use the slave view.
interface acq_search_ctrl_if #(
    parameter int unsigned N_DOPPLER   = 21,
    parameter int unsigned CODE_PHASES = 1023,
    parameter int unsigned MAG_W       = 24
);
    localparam int unsigned DW = (N_DOPPLER > 1) ? $clog2(N_DOPPLER) : 1;
    localparam int unsigned PW = (CODE_PHASES > 1) ? $clog2(CODE_PHASES) : 1;

    logic             corr_start;
    logic [5:0]       corr_prn;
    logic [DW-1:0]    corr_dopp_idx;
    logic [PW-1:0]    corr_code_phase;
    logic             corr_done;
    logic [MAG_W-1:0] corr_mag;

    logic             res_valid;
    logic             res_ready;
    logic [5:0]       res_prn;
    logic [DW-1:0]    res_dopp_idx;
    logic [PW-1:0]    res_code_phase;
    logic [MAG_W-1:0] res_mag;
    logic             res_found;

    modport master (
        output corr_start, corr_prn, corr_dopp_idx, corr_code_phase,
        input  corr_done, corr_mag,
        output res_valid, res_prn, res_dopp_idx, res_code_phase, res_mag, res_found,
        input  res_ready
    );

    modport slave (
        input  corr_start, corr_prn, corr_dopp_idx, corr_code_phase,
        output corr_done, corr_mag,
        input  res_valid, res_prn, res_dopp_idx, res_code_phase, res_mag, res_found,
        output res_ready
    );
endinterface

// File: rtl/acq_search_ctrl.sv
// Acquisition search sequencer: sweeps PRN x Doppler x code phase through the shared correlator,
// tracks the peak cell per PRN and emits one found/not-found record per PRN.
module acq_search_ctrl #(
    parameter int unsigned N_DOPPLER   = 21,
    parameter int unsigned CODE_PHASES = 1023,
    parameter int unsigned MAG_W       = 24,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [5:0]       prn_first,
    input  logic [5:0]       prn_last,
    input  logic [MAG_W-1:0] threshold,
    acq_search_ctrl_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             error
);
    localparam int unsigned DW = (N_DOPPLER > 1) ? $clog2(N_DOPPLER) : 1;
    localparam int unsigned PW = (CODE_PHASES > 1) ? $clog2(CODE_PHASES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [DW-1:0] DOPP_LAST  = DW'(N_DOPPLER - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CODE_PHASES - 1);
    localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_WAIT,
        S_EVAL,
        S_REPORT
    } state_t;

    state_t           state, state_d;

    logic [5:0]       prn_q, prn_d;
    logic [5:0]       prn_last_q, prn_last_d;
    logic [DW-1:0]    dopp_q, dopp_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [MAG_W-1:0] thr_q, thr_d;
    logic [MAG_W-1:0] mag_q, mag_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;

    logic [MAG_W-1:0] best_mag_q, best_mag_d;
    logic [DW-1:0]    best_dopp_q, best_dopp_d;
    logic [PW-1:0]    best_phase_q, best_phase_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             corr_start_q, corr_start_d;
    logic             res_valid_q, res_valid_d;
    logic             res_found_q, res_found_d;
    logic [5:0]       res_prn_q, res_prn_d;
    logic [DW-1:0]    res_dopp_q, res_dopp_d;
    logic [PW-1:0]    res_phase_q, res_phase_d;
    logic [MAG_W-1:0] res_mag_q, res_mag_d;

    // State register and all registered outputs
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            prn_q        <= '0;
            prn_last_q   <= '0;
            dopp_q       <= '0;
            phase_q      <= '0;
            thr_q        <= '0;
            mag_q        <= '0;
            tcnt_q       <= '0;
            best_mag_q   <= '0;
            best_dopp_q  <= '0;
            best_phase_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            corr_start_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_found_q  <= 1'b0;
            res_prn_q    <= '0;
            res_dopp_q   <= '0;
            res_phase_q  <= '0;
            res_mag_q    <= '0;
        end else begin
            state        <= state_d;
            prn_q        <= prn_d;
            prn_last_q   <= prn_last_d;
            dopp_q       <= dopp_d;
            phase_q      <= phase_d;
            thr_q        <= thr_d;
            mag_q        <= mag_d;
            tcnt_q       <= tcnt_d;
            best_mag_q   <= best_mag_d;
            best_dopp_q  <= best_dopp_d;
            best_phase_q <= best_phase_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            corr_start_q <= corr_start_d;
            res_valid_q  <= res_valid_d;
            res_found_q  <= res_found_d;
            res_prn_q    <= res_prn_d;
            res_dopp_q   <= res_dopp_d;
            res_phase_q  <= res_phase_d;
            res_mag_q    <= res_mag_d;
        end
    end

    // Next state, counters and best-cell tracking; outputs are decoded from the next state
    always_comb begin
        state_d      = state;
        prn_d        = prn_q;
        prn_last_d   = prn_last_q;
        dopp_d       = dopp_q;
        phase_d      = phase_q;
        thr_d        = thr_q;
        mag_d        = mag_q;
        tcnt_d       = tcnt_q;
        best_mag_d   = best_mag_q;
        best_dopp_d  = best_dopp_q;
        best_phase_d = best_phase_q;
        error_d      = error_q;
        done_d       = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (prn_first <= prn_last) begin
                            prn_d        = prn_first;
                            prn_last_d   = prn_last;
                            thr_d        = threshold;
                            dopp_d       = '0;
                            phase_d      = '0;
                            best_mag_d   = '0;
                            best_dopp_d  = '0;
                            best_phase_d = '0;
                            error_d      = 1'b0;
                            state_d      = S_CONFIG;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                S_CONFIG: begin
                    tcnt_d  = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.corr_done) begin
                        mag_d   = bus.corr_mag;
                        state_d = S_EVAL;
                    end else if (tcnt_q == TCNT_LAST) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        tcnt_d = TW'(tcnt_q + TW'(1));
                    end
                end
                S_EVAL: begin
                    // Strict compare so ties keep the earliest cell in sweep order
                    if (mag_q > best_mag_q) begin
                        best_mag_d   = mag_q;
                        best_dopp_d  = dopp_q;
                        best_phase_d = phase_q;
                    end
                    if (phase_q != PHASE_LAST) begin
                        phase_d = PW'(phase_q + PW'(1));
                        state_d = S_CONFIG;
                    end else if (dopp_q != DOPP_LAST) begin
                        phase_d = '0;
                        dopp_d  = DW'(dopp_q + DW'(1));
                        state_d = S_CONFIG;
                    end else begin
                        state_d = S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (bus.res_ready) begin
                        best_mag_d   = '0;
                        best_dopp_d  = '0;
                        best_phase_d = '0;
                        if (prn_q == prn_last_q) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            prn_d   = 6'(prn_q + 6'd1);
                            dopp_d  = '0;
                            phase_d = '0;
                            state_d = S_CONFIG;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d       = (state_d != S_IDLE);
        corr_start_d = (state_d == S_CONFIG);
        res_valid_d  = (state_d == S_REPORT);
        res_prn_d    = res_valid_d ? prn_d : '0;
        res_dopp_d   = res_valid_d ? best_dopp_d : '0;
        res_phase_d  = res_valid_d ? best_phase_d : '0;
        res_mag_d    = res_valid_d ? best_mag_d : '0;
        res_found_d  = res_valid_d && (best_mag_d > thr_d);
    end

    assign bus.corr_start      = corr_start_q;
    assign bus.corr_prn        = prn_q;
    assign bus.corr_dopp_idx   = dopp_q;
    assign bus.corr_code_phase = phase_q;
    assign bus.res_valid       = res_valid_q;
    assign bus.res_prn         = res_prn_q;
    assign bus.res_dopp_idx    = res_dopp_q;
    assign bus.res_code_phase  = res_phase_q;
    assign bus.res_mag         = res_mag_q;
    assign bus.res_found       = res_found_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign error               = error_q;
endmodule

// File: tb/tb_acq_search_ctrl.sv
// Bench for acq_search_ctrl: a behavioural correlator answers requests from a magnitude table,
// and each PRN record is checked against the table's peak cell.
module tb_acq_search_ctrl;
    localparam int unsigned ND = 3;
    localparam int unsigned NP = 4;
    localparam int unsigned MW = 24;
    localparam int unsigned TO = 16;

    logic          sys_clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [5:0]    prn_first;
    logic [5:0]    prn_last;
    logic [MW-1:0] threshold;
    logic          busy;
    logic          done;
    logic          error;

    acq_search_ctrl_if #(.N_DOPPLER(ND), .CODE_PHASES(NP), .MAG_W(MW)) bus ();

    acq_search_ctrl #(
        .N_DOPPLER(ND), .CODE_PHASES(NP), .MAG_W(MW), .TIMEOUT_CYC(TO)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .prn_first (prn_first),
        .prn_last  (prn_last),
        .threshold (threshold),
        .bus       (bus.master),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 sys_clk = ~sys_clk;

    int          checks   = 0;
    int          failures = 0;
    int          n_start  = 0;
    int          start_base = 0;
    int          lat      = 3;
    bit          resp_on  = 1'b1;
    int unsigned mag_tab [0:63][0:ND-1][0:NP-1];

    always @(posedge sys_clk) if (bus.corr_start === 1'b1) n_start <= n_start + 1;

    // Correlator model: answers each request after lat cycles with the table magnitude of the cell
    initial begin
        int rp, rd, rc;
        bus.corr_done = 1'b0;
        bus.corr_mag  = '0;
        forever begin
            @(posedge sys_clk);
            if (bus.corr_start === 1'b1 && resp_on) begin
                rp = int'(bus.corr_prn);
                rd = int'(bus.corr_dopp_idx);
                rc = int'(bus.corr_code_phase);
                repeat (lat - 1) @(posedge sys_clk);
                #1;
                bus.corr_done = 1'b1;
                bus.corr_mag  = MW'(mag_tab[rp][rd][rc]);
                @(posedge sys_clk);
                #1;
                bus.corr_done = 1'b0;
                bus.corr_mag  = '0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_const(input int prn, input int unsigned v);
        for (int d = 0; d < int'(ND); d++)
            for (int p = 0; p < int'(NP); p++)
                mag_tab[prn][d][p] = v;
    endtask

    task automatic fill_rand(input int prn, input int unsigned maxv);
        for (int d = 0; d < int'(ND); d++)
            for (int p = 0; p < int'(NP); p++)
                mag_tab[prn][d][p] = $urandom_range(maxv, 0);
    endtask

    // Peak cell of a PRN: largest magnitude, first occurrence in sweep order, (0,0) if all zero
    task automatic model(input int prn, output int bd, output int bp, output int unsigned bm);
        bit hit;
        bm = 0;
        for (int d = 0; d < int'(ND); d++)
            for (int p = 0; p < int'(NP); p++)
                if (mag_tab[prn][d][p] > bm) bm = mag_tab[prn][d][p];
        bd = 0;
        bp = 0;
        hit = 1'b0;
        if (bm != 0)
            for (int d = 0; d < int'(ND); d++)
                for (int p = 0; p < int'(NP); p++)
                    if (!hit && mag_tab[prn][d][p] == bm) begin
                        bd = d;
                        bp = p;
                        hit = 1'b1;
                    end
    endtask

    task automatic do_start(input int f, input int l, input int unsigned thr);
        prn_first  = 6'(f);
        prn_last   = 6'(l);
        threshold  = MW'(thr);
        start      = 1'b1;
        start_base = n_start;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (bus.res_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic consume(input int f, input int l, input int unsigned thr, input bit hold);
        bit ok, stable;
        int bd, bp, dcnt, ns;
        int unsigned bm;
        for (int prn = f; prn <= l; prn++) begin
            wait_valid(ok);
            chk("rec_valid", 64'(ok), 64'(1));
            if (!ok) return;
            model(prn, bd, bp, bm);
            chk("rec_prn",   64'(bus.res_prn),        64'(prn));
            chk("rec_dopp",  64'(bus.res_dopp_idx),   64'(bd));
            chk("rec_phase", 64'(bus.res_code_phase), 64'(bp));
            chk("rec_mag",   64'(bus.res_mag),        64'(bm));
            chk("rec_found", 64'(bus.res_found),      64'(bm > thr));
            if (hold && prn == f) begin
                ns = n_start;
                stable = 1'b1;
                repeat (10) begin
                    @(posedge sys_clk);
                    #1;
                    if (bus.res_valid !== 1'b1 || bus.res_prn !== 6'(prn) ||
                        bus.res_dopp_idx !== 2'(bd) || bus.res_code_phase !== 2'(bp) ||
                        bus.res_mag !== MW'(bm)) stable = 1'b0;
                end
                chk("hold_stable",   64'(stable),     64'(1));
                chk("hold_no_start", 64'(n_start - ns), 64'(0));
            end
            bus.res_ready = 1'b1;
            @(posedge sys_clk);
            #1;
            bus.res_ready = 1'b0;
            dcnt = 0;
            for (int k = 0; k < 3; k++) begin
                dcnt += int'(done);
                if (k < 2) begin
                    @(posedge sys_clk);
                    #1;
                end
            end
            chk("done_pulses", 64'(dcnt), 64'((prn == l) ? 1 : 0));
        end
        chk("cell_count", 64'(n_start - start_base), 64'((l - f + 1) * int'(ND * NP)));
        chk("idle_after", 64'(busy), 64'(0));
    endtask

    initial begin
        bit ok, seen;
        int f, l, cnt;
        int unsigned thr;
        logic [63:0] vec;

        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        prn_first = '0; prn_last = '0; threshold = '0;
        bus.res_ready = 1'b0;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        vec = 64'({busy, done, error, bus.corr_start, bus.res_valid, bus.res_found,
                   bus.res_prn, bus.corr_prn, bus.corr_dopp_idx, bus.corr_code_phase});
        chk("reset_outputs", vec, 64'(0));
        chk("reset_res_mag", 64'(bus.res_mag), 64'(0));
        rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        // Single peak at d1/p2 above threshold
        for (int p = 0; p < 64; p++) fill_const(p, 10);
        mag_tab[5][1][2] = 200;
        lat = 3;
        do_start(5, 5, 100);
        consume(5, 5, 100, 1'b0);

        // Flat magnitudes: ties keep d0/p0, below threshold
        for (int p = 1; p <= 3; p++) fill_const(p, 50);
        do_start(1, 3, 500);
        consume(1, 3, 500, 1'b0);

        // Back-pressure on the first record of a random sweep
        for (int p = 10; p <= 12; p++) fill_rand(p, 32'h00FF_FFFF);
        lat = $urandom_range(4, 1);
        thr = $urandom_range(32'h00FF_FFFF, 0);
        do_start(10, 12, thr);
        consume(10, 12, thr, 1'b1);

        // Random sweeps alternating tie-heavy and wide magnitude ranges
        for (int it = 0; it < 4; it++) begin
            f = $urandom_range(30, 1);
            l = f + $urandom_range(2, 0);
            for (int p = f; p <= l; p++) fill_rand(p, (it % 2 == 0) ? 3 : 32'h00FF_FFFF);
            thr = (it % 2 == 0) ? $urandom_range(3, 0) : $urandom_range(32'h00FF_FFFF, 0);
            lat = $urandom_range(4, 1);
            do_start(f, l, thr);
            consume(f, l, thr, 1'b0);
        end

        // Correlator never answers: timeout after CONFIG plus TO wait cycles
        resp_on = 1'b0;
        do_start(2, 2, 0);
        cnt = 0;
        seen = 1'b0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            seen = seen | done | bus.res_valid;
            @(posedge sys_clk);
            #1;
        end
        chk("timeout_busy_cycles", 64'(cnt),   64'(1 + TO));
        chk("timeout_error",       64'(error), 64'(1));
        chk("timeout_no_rec_done", 64'(seen | done | bus.res_valid), 64'(0));
        resp_on = 1'b1;

        // abort together with start in IDLE: start ignored, error kept
        prn_first = 6'd1; prn_last = 6'd1;
        start = 1'b1; abort = 1'b1;
        @(posedge sys_clk);
        #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy",  64'(busy),  64'(0));
        chk("abort_start_error", 64'(error), 64'(1));

        fill_rand(3, 3);
        lat = 2;
        do_start(3, 3, 1);
        chk("start_clears_error", 64'(error), 64'(0));
        consume(3, 3, 1, 1'b0);

        // abort during WAIT of cell index 7 with a slow correlator
        fill_rand(7, 1000);
        lat = 10;
        do_start(7, 7, 0);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge sys_clk);
            #1;
            if (n_start - start_base == 8) begin
                ok = 1'b1;
                break;
            end
        end
        chk("abort_reached_cell7", 64'(ok), 64'(1));
        abort = 1'b1;
        @(posedge sys_clk);
        #1;
        abort = 1'b0;
        chk("abort_busy",      64'(busy), 64'(0));
        chk("abort_outputs",   64'({bus.corr_start, bus.res_valid, done}), 64'(0));
        seen = 1'b0;
        repeat (14) begin
            @(posedge sys_clk);
            #1;
            seen = seen | busy | bus.res_valid | done;
        end
        chk("late_done_ignored", 64'(seen),  64'(0));
        chk("abort_error_kept",  64'(error), 64'(0));
        lat = 2;
        do_start(7, 7, 500);
        chk("restart_cell0", 64'({bus.corr_start, bus.corr_prn, bus.corr_dopp_idx, bus.corr_code_phase}),
            64'({1'b1, 6'd7, 2'd0, 2'd0}));
        consume(7, 7, 500, 1'b0);

        // Reversed range is rejected
        do_start(9, 4, 0);
        chk("bad_range_error", 64'(error), 64'(1));
        chk("bad_range_busy",  64'(busy),  64'(0));
        @(posedge sys_clk);
        #1;
        chk("bad_range_idle",  64'({busy, bus.corr_start}), 64'(0));

        // start while busy with a different range is ignored
        fill_rand(1, 32'h00FF_FFFF);
        fill_rand(2, 32'h00FF_FFFF);
        thr = $urandom_range(32'h00FF_FFFF, 0);
        lat = 1;
        do_start(1, 2, thr);
        repeat (5) @(posedge sys_clk);
        #1;
        prn_first = 6'd20; prn_last = 6'd20; threshold = '0;
        start = 1'b1;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        consume(1, 2, thr, 1'b0);

        // Asynchronous reset while a record is waiting
        fill_rand(4, 255);
        do_start(4, 4, 0);
        wait_valid(ok);
        chk("pre_reset_valid", 64'(ok), 64'(1));
        rst_n = 1'b0;
        #1;
        vec = 64'({busy, done, error, bus.corr_start, bus.res_valid, bus.res_found,
                   bus.res_prn, bus.corr_prn, bus.corr_dopp_idx, bus.corr_code_phase});
        chk("mid_report_reset",     vec, 64'(0));
        chk("mid_report_reset_mag", 64'(bus.res_mag), 64'(0));
        repeat (2) @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("post_reset_idle", 64'({busy, bus.res_valid, bus.corr_start}), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
